// File: rtl/td4_fetch_decode.sv
// rtl/td4_fetch_decode.sv - TD4 fetch/decode stage with writable program store and PROG/RUN/HALT control
// Optional: define TD4_SELF_JMP_HALT_EN to halt on a jump-to-self instruction.
module td4_fetch_decode #(
  parameter int ROM_DEPTH   = 16,
  parameter int RESET_STATE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pc_in,
  input  logic       carry_flag,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       run_start,
  input  logic       halt_req,
  output logic       pc_load,
  output logic [3:0] pc_imm,
  output logic [3:0] imm,
  output logic [1:0] src_sel,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_out,
  output logic [1:0] state,
  output logic       illegal
);

  typedef enum logic [1:0] {
    S_PROG = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [1:0] SRC_A    = 2'd0;
  localparam logic [1:0] SRC_B    = 2'd1;
  localparam logic [1:0] SRC_IN   = 2'd2;
  localparam logic [1:0] SRC_ZERO = 2'd3;

  state_t     st;
  logic [7:0] rom [ROM_DEPTH];
  logic [3:0] op;
  logic [3:0] im;
  logic       op_legal;

  assign op    = rom[pc_in][7:4];
  assign im    = rom[pc_in][3:0];
  assign state = st;

  // Program store is deliberately left out of reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (st == S_PROG && prog_we) begin
      rom[prog_addr] <= prog_data;
    end
  end

`ifdef TD4_SELF_JMP_HALT_EN
  logic self_jmp;
  assign self_jmp = (op == 4'hF) && (im == pc_in);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= (RESET_STATE != 0) ? S_RUN : S_PROG;
      illegal <= 1'b0;
    end else begin
      case (st)
        S_PROG: if (run_start) st <= S_RUN;
        S_RUN: begin
          if (!op_legal) illegal <= 1'b1;
          if (halt_req) st <= S_HALT;
`ifdef TD4_SELF_JMP_HALT_EN
          else if (self_jmp) st <= S_HALT;
`endif
        end
        S_HALT: if (run_start) st <= S_PROG;
        default: st <= S_PROG;
      endcase
    end
  end

  always_comb begin
    pc_load  = 1'b1;
    pc_imm   = 4'd0;
    imm      = 4'd0;
    src_sel  = SRC_ZERO;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_out   = 1'b0;
    op_legal = 1'b1;
    case (st)
      S_RUN: begin
        pc_load = 1'b0;
        pc_imm  = im;
        imm     = im;
        case (op)
          4'b0000: begin src_sel = SRC_A;    ld_a   = 1'b1; end
          4'b0101: begin src_sel = SRC_B;    ld_b   = 1'b1; end
          4'b0011: begin src_sel = SRC_ZERO; ld_a   = 1'b1; end
          4'b0111: begin src_sel = SRC_ZERO; ld_b   = 1'b1; end
          4'b0001: begin src_sel = SRC_B;    ld_a   = 1'b1; imm = 4'd0; end
          4'b0100: begin src_sel = SRC_A;    ld_b   = 1'b1; imm = 4'd0; end
          4'b0010: begin src_sel = SRC_IN;   ld_a   = 1'b1; end
          4'b0110: begin src_sel = SRC_IN;   ld_b   = 1'b1; end
          4'b1001: begin src_sel = SRC_B;    ld_out = 1'b1; end
          4'b1011: begin src_sel = SRC_ZERO; ld_out = 1'b1; end
          4'b1111: pc_load = 1'b1;
          4'b1110: pc_load = ~carry_flag;
          default: op_legal = 1'b0;
        endcase
      end
      // HALT re-loads the current PC so it stays frozen.
      S_HALT: pc_imm = pc_in;
      default: ;
    endcase
  end

endmodule

// File: doc/td4_fetch_decode.md
Name: td4_fetch_decode

Overview:
- Instruction fetch/decode stage directly downstream of the 4-bit program counter. It consumes the PC value and feeds the PC's load control and load data back.
- Holds a 16x8 writable program store and fetches rom[pc_in] each cycle.
- Decodes TD4-style opcodes into register-load and source-select strobes plus PC jump control.
- Run-control FSM (PROG/RUN/HALT) drives the PC, which has no enable or reset of its own:
  - PROG forces PC to 0.
  - HALT freezes PC.

Parameters:
- ROM_DEPTH, 16, program store entries; must equal 2^width(pc_in).
- RESET_STATE, 0, FSM state after rst: 0 = PROG, 1 = RUN.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- pc_in  in  4  current PC value (PC register output).
- carry_flag  in  1  registered ALU carry from previous instruction.
- prog_we  in  1  program-store write strobe, honoured only in PROG.
- prog_addr  in  4  program-store write address.
- prog_data  in  8  program-store write data: opcode[7:4], imm[3:0].
- run_start  in  1  PROG->RUN or HALT->PROG request (one-cycle pulse).
- halt_req  in  1  RUN->HALT request.
- pc_load  out  1  to PC ctrl; 1 = load pc_imm, 0 = increment.
- pc_imm  out  4  to PC A input.
- imm  out  4  immediate field to ALU.
- src_sel  out  2  ALU source: 0 = A, 1 = B, 2 = IN port, 3 = zero.
- ld_a  out  1  write ALU result to register A.
- ld_b  out  1  write ALU result to register B.
- ld_out  out  1  write ALU result to output port.
- state  out  2  0 = PROG, 1 = RUN, 2 = HALT.
- illegal  out  1  sticky; set on fetch of an undefined opcode in RUN.

Behaviour:
- Reset (rst=1 at clk edge):
  - state = RESET_STATE; illegal = 0.
  - Program store NOT cleared.
  - Outputs follow state decode (below).
- Program store:
  - Synchronous write when state == PROG && prog_we: rom[prog_addr] <= prog_data.
  - Asynchronous read of rom[pc_in].
  - Write in any other state is ignored.
- FSM:
  - PROG --run_start--> RUN.
  - RUN --halt_req--> HALT.
  - HALT --run_start--> PROG.
  - If run_start and halt_req are both asserted in RUN, halt_req wins.
  - run_start in RUN is ignored; halt_req in PROG/HALT is ignored.
- PROG outputs:
  - pc_load = 1, pc_imm = 0 (PC held at 0).
  - All ld_* = 0, src_sel = 3, imm = 0.
- HALT outputs:
  - pc_load = 1, pc_imm = pc_in (PC frozen).
  - All ld_* = 0.
- RUN outputs: combinational decode of op = rom[pc_in][7:4], im = rom[pc_in][3:0]; imm = im always. Defaults: pc_load = 0, pc_imm = im, ld_* = 0, src_sel = 3.
  - 0000 ADD A,Im: src=A, ld_a.
  - 0101 ADD B,Im: src=B, ld_b.
  - 0011 MOV A,Im: src=zero, ld_a.
  - 0111 MOV B,Im: src=zero, ld_b.
  - 0001 MOV A,B: src=B, ld_a, imm forced 0.
  - 0100 MOV B,A: src=A, ld_b, imm forced 0.
  - 0010 IN A: src=IN, ld_a.
  - 0110 IN B: src=IN, ld_b.
  - 1001 OUT B: src=B, ld_out.
  - 1011 OUT Im: src=zero, ld_out.
  - 1111 JMP: pc_load = 1.
  - 1110 JNC: pc_load = ~carry_flag.
  - Any other opcode: behaves as NOP; illegal <= 1 at the clock edge.
- Timing:
  - One instruction per cycle; zero-latency decode from pc_in.
  - The jump target appears on PC output one clock after the JMP cycle.
- Wrap-around: PC 15 -> 0 is handled by the PC; no special action here.
- Mid-operation:
  - rst mid-RUN returns the FSM to RESET_STATE on the same edge.
  - The ld_* strobes of that cycle are still combinationally visible before the edge; the register stage must qualify them with rst.

Optional Feature:
- Macro: TD4_SELF_JMP_HALT_EN.
- Defined: in RUN, if op == 1111 && im == pc_in (jump-to-self), the FSM enters HALT at that clock edge; pc_load/pc_imm still present the jump in that cycle.
- Undefined: jump-to-self loops forever in RUN; only halt_req stops execution.

Test Plan:
- PROG load:
  - Stimulus: rst; write rom[0] = 0x35, rom[1] = 0x72, rom[2] = 0xF0 via prog_we; pulse run_start.
  - Response: state = 1; pc_in = 0 decodes ld_a = 1, src_sel = 3, imm = 5.
  - Response: pc_in = 1 decodes ld_b = 1, imm = 2.
  - Response: pc_in = 2 gives pc_load = 1, pc_imm = 0.
- JNC:
  - Stimulus: rom[3] = 0xE9 with carry_flag = 0, then with carry_flag = 1.
  - Response: pc_load = 1, pc_imm = 9 (carry 0); pc_load = 0 (carry 1).
- Ignored write: prog_we in RUN with prog_addr = 0, prog_data = 0xFF -> rom[0] still 0x35 after returning to PROG.
- Halt/priority:
  - Stimulus: halt_req and run_start in the same RUN cycle.
  - Response: state = 2; pc_load = 1, pc_imm = pc_in; PC constant over 5 cycles.
  - Then: run_start -> state = 0, PC reaches 0 next cycle.
- Illegal opcode: fetch 0x8A in RUN -> all ld_* = 0, pc_load = 0, illegal = 1 next cycle and remains 1 until rst.
- Self-jump (macro defined): rom[4] = 0xF4 -> state = 2 one edge after pc_in = 4. With macro undefined, state stays 1.
